// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Control bundle between the multicycle control FSM and the
//                8-bit datapath. The controller drives the mux selects,
//                write enables, ALU controls and a debug copy of its state.
//                The datapath supplies the instruction register and the
//                registered N/Z flags.
//  Modports    : master - controller side (IR/N/Z in, controls out)
//                slave  - datapath side  (IR/N/Z out, controls in)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
  logic [7:0] IR;
  logic       N;
  logic       Z;
  logic       PCwrite;
  logic       AddrSel;
  logic       MemRead;
  logic       MemWrite;
  logic       IRload;
  logic       MDRload;
  logic       OpASel;
  logic       RegIn;
  logic       RFWrite;
  logic       ALU1;
  logic [2:0] ALU2;
  logic [2:0] ALUop;
  logic       FlagWrite;
  logic [3:0] state_dbg;

  modport master (
    input  IR, N, Z,
    output PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, OpASel,
           RegIn, RFWrite, ALU1, ALU2, ALUop, FlagWrite, state_dbg
  );

  modport slave (
    output IR, N, Z,
    input  PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, OpASel,
           RegIn, RFWrite, ALU1, ALU2, ALUop, FlagWrite, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore control FSM for the 8-bit multicycle processor.
//                Sequences each instruction through fetch, decode and the
//                class-specific execute states. Outputs are a combinational
//                function of the current state and IR; write enables are
//                additionally gated off while reset is high.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous, active-high
//                bus   - multicycle_control_if.master (IR/N/Z in, controls out)
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LD1    = 4'd3,
    S_LD2    = 4'd4,
    S_ST     = 4'd5,
    S_ALU    = 4'd6,
    S_WB     = 4'd7,
    S_BR     = 4'd8
  } state_t;

  state_t r_state;

  // Instruction decode. ori and shift are identified by the low three bits
  // alone; the remaining opcodes use the full low nibble. None of the nibble
  // codes collide with 111/011, so the priority only matters conceptually.
  logic w_ori, w_shift, w_load, w_store, w_add, w_sub, w_nand;
  logic w_bz, w_bnz, w_bpz, w_alu, w_br, w_taken;
  logic w_unused_ir;

  assign w_ori   = (bus.IR[2:0] == 3'b111);
  assign w_shift = !w_ori && (bus.IR[2:0] == 3'b011);
  assign w_load  = (bus.IR[3:0] == 4'b0000);
  assign w_store = (bus.IR[3:0] == 4'b0010);
  assign w_add   = (bus.IR[3:0] == 4'b0100);
  assign w_sub   = (bus.IR[3:0] == 4'b0110);
  assign w_nand  = (bus.IR[3:0] == 4'b1000);
  assign w_bz    = (bus.IR[3:0] == 4'b0101);
  assign w_bnz   = (bus.IR[3:0] == 4'b1001);
  assign w_bpz   = (bus.IR[3:0] == 4'b1101);
  assign w_alu   = w_ori || w_shift || w_add || w_sub || w_nand;
  assign w_br    = w_bz || w_bnz || w_bpz;
  assign w_taken = (w_bz && bus.Z) || (w_bnz && !bus.Z) || (w_bpz && !bus.N);

  // Register fields are consumed by the datapath, not by the controller.
  assign w_unused_ir = ^bus.IR[7:4];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RESET;
    end else begin
      case (r_state)
        S_RESET:  r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          if (w_load)       r_state <= S_LD1;
          else if (w_store) r_state <= S_ST;
          else if (w_alu)   r_state <= S_ALU;
          else if (w_br)    r_state <= S_BR;
          else              r_state <= S_FETCH;  // undefined opcode acts as NOP
        end
        S_LD1:    r_state <= S_LD2;
        S_LD2:    r_state <= S_FETCH;
        S_ST:     r_state <= S_FETCH;
        S_ALU:    r_state <= S_WB;
        S_WB:     r_state <= S_FETCH;
        S_BR:     r_state <= S_FETCH;
        default:  r_state <= S_RESET;  // illegal encodings recover via reset
      endcase
    end
  end

  always_comb begin
    bus.PCwrite   = 1'b0;
    bus.AddrSel   = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRload    = 1'b0;
    bus.MDRload   = 1'b0;
    bus.OpASel    = 1'b0;
    bus.RegIn     = 1'b0;
    bus.RFWrite   = 1'b0;
    bus.ALU1      = 1'b0;
    bus.ALU2      = 3'b000;
    bus.ALUop     = 3'b000;
    bus.FlagWrite = 1'b0;
    bus.state_dbg = r_state;

    case (r_state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRload  = 1'b1;
        bus.ALU2    = 3'b001;  // PC + 1
        bus.PCwrite = 1'b1;
      end
      S_DECODE: bus.OpASel = w_ori;  // ori reads R1 as its source/destination
      S_LD1: begin
        bus.AddrSel = 1'b1;
        bus.MemRead = 1'b1;
        bus.MDRload = 1'b1;
      end
      S_LD2: begin
        bus.RegIn   = 1'b1;
        bus.RFWrite = 1'b1;
      end
      S_ST: begin
        bus.AddrSel  = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_ALU: begin
        bus.ALU1   = 1'b1;
        bus.OpASel = w_ori;
        if (w_ori) begin
          bus.ALU2  = 3'b011;
          bus.ALUop = 3'b011;
        end else if (w_shift) begin
          bus.ALU2  = 3'b100;
          bus.ALUop = 3'b100;
        end else if (w_sub) begin
          bus.ALUop = 3'b001;
        end else if (w_nand) begin
          bus.ALUop = 3'b010;
        end
      end
      S_WB: begin
        bus.RFWrite   = 1'b1;
        bus.FlagWrite = 1'b1;
        bus.OpASel    = w_ori;  // destination must match the ALU source
      end
      S_BR: begin
        bus.ALU2    = 3'b010;   // PC (already incremented) + Imm4
        bus.PCwrite = w_taken;
      end
      default: ;
    endcase

    // Reset blocks every architectural write immediately, not one edge later.
    if (reset) begin
      bus.PCwrite   = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.IRload    = 1'b0;
      bus.MDRload   = 1'b0;
      bus.RFWrite   = 1'b0;
      bus.FlagWrite = 1'b0;
    end
  end

endmodule
`default_nettype wire
